pc_sequencer: RTL and testbench

- Owns the program counter of the single-cycle RISC-V core and selects the next PC each cycle.
- Sources: the pc+4 incrementer, the branch target, the jump target, the trap vector and the saved exception PC.
- Contains a 4-state control FSM (boot, run, handler, halt) and detects misaligned control-flow targets.
- Sits between the decode/branch-compare logic and instruction memory; drives the instruction-memory address.

---
 rtl/pc_sequencer_if.sv | 38 +++
 rtl/pc_sequencer.sv | 124 ++++++++++++
 tb/tb_pc_sequencer.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_if.sv
// Control/redirect bundle between the decode/branch logic and the PC sequencer.
// PC_SEQ_INSTRET_EN adds the 64-bit retired-instruction count to the bundle.
interface pc_sequencer_if;
    logic        stall_i;
    logic        branch_taken_i;
    logic [31:0] branch_target_i;
    logic        jump_i;
    logic [31:0] jump_target_i;
    logic        trap_i;
    logic        mret_i;
    logic [31:0] pc_o;
    logic [31:0] pc_plus4_o;
    logic [31:0] epc_o;
    logic        fetch_valid_o;
    logic        misalign_o;
    logic [1:0]  state_o;
`ifdef PC_SEQ_INSTRET_EN
    logic [63:0] instret_o;

    modport master (
        output stall_i, branch_taken_i, branch_target_i, jump_i, jump_target_i, trap_i, mret_i,
        input  pc_o, pc_plus4_o, epc_o, fetch_valid_o, misalign_o, state_o, instret_o
    );
    modport slave (
        input  stall_i, branch_taken_i, branch_target_i, jump_i, jump_target_i, trap_i, mret_i,
        output pc_o, pc_plus4_o, epc_o, fetch_valid_o, misalign_o, state_o, instret_o
    );
`else
    modport master (
        output stall_i, branch_taken_i, branch_target_i, jump_i, jump_target_i, trap_i, mret_i,
        input  pc_o, pc_plus4_o, epc_o, fetch_valid_o, misalign_o, state_o
    );
    modport slave (
        input  stall_i, branch_taken_i, branch_target_i, jump_i, jump_target_i, trap_i, mret_i,
        output pc_o, pc_plus4_o, epc_o, fetch_valid_o, misalign_o, state_o
    );
`endif
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter owner and next-PC selector with boot/run/handler/halt control FSM.
// Optional feature macro: PC_SEQ_INSTRET_EN (64-bit retired-instruction counter).
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
    input  logic          clk,
    input  logic          rst_n,
    pc_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        ST_BOOT    = 2'd0,
        ST_RUN     = 2'd1,
        ST_HANDLER = 2'd2,
        ST_HALT    = 2'd3
    } state_t;

    state_t      state_r;
    state_t      next_state_s;
    logic [31:0] pc_r;
    logic [31:0] next_pc_s;
    logic [31:0] epc_r;
    logic [31:0] next_epc_s;
    logic        fetch_valid_r;
    logic        misalign_r;
    logic        misalign_s;
    logic        retire_s;
    logic [31:0] target_s;
    logic        mis_redirect_s;

    // Jump outranks branch, so its target is the one checked for alignment.
    assign target_s       = bus.jump_i ? bus.jump_target_i : bus.branch_target_i;
    assign mis_redirect_s = (bus.jump_i | bus.branch_taken_i) & (target_s[1:0] != 2'b00) & ~bus.stall_i;

    // Next-state, next-PC and event selection in priority order.
    always_comb begin
        next_state_s = state_r;
        next_pc_s    = pc_r;
        next_epc_s   = epc_r;
        misalign_s   = 1'b0;
        retire_s     = 1'b0;
        case (state_r)
            ST_BOOT: begin
                next_state_s = ST_RUN;
            end
            ST_RUN, ST_HANDLER: begin
                if (bus.trap_i || mis_redirect_s) begin
                    misalign_s = ~bus.trap_i;
                    if (state_r == ST_RUN) begin
                        next_epc_s   = pc_r;
                        next_pc_s    = TRAP_VECTOR;
                        next_state_s = ST_HANDLER;
                    end else begin
                        next_state_s = ST_HALT;
                    end
                end else if (bus.stall_i) begin
                    next_pc_s = pc_r;
                end else if (bus.mret_i && (state_r == ST_HANDLER)) begin
                    next_pc_s    = epc_r;
                    next_state_s = ST_RUN;
                    retire_s     = 1'b1;
                end else if (bus.jump_i) begin
                    next_pc_s = bus.jump_target_i;
                    retire_s  = 1'b1;
                end else if (bus.branch_taken_i) begin
                    next_pc_s = bus.branch_target_i;
                    retire_s  = 1'b1;
                end else begin
                    next_pc_s = pc_r + 32'd4;
                    retire_s  = 1'b1;
                end
            end
            ST_HALT: begin
                next_state_s = ST_HALT;
            end
            default: begin
                next_state_s = ST_HALT;
            end
        endcase
    end

    // Architectural state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_BOOT;
            pc_r          <= RESET_VECTOR;
            epc_r         <= 32'h0000_0000;
            fetch_valid_r <= 1'b0;
            misalign_r    <= 1'b0;
        end else begin
            state_r       <= next_state_s;
            pc_r          <= next_pc_s;
            epc_r         <= next_epc_s;
            fetch_valid_r <= (next_state_s == ST_RUN) || (next_state_s == ST_HANDLER);
            misalign_r    <= misalign_s;
        end
    end

`ifdef PC_SEQ_INSTRET_EN
    logic [63:0] instret_r;

    // Retired-instruction counter, wraps naturally at 2^64.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instret_r <= 64'd0;
        end else if (retire_s) begin
            instret_r <= instret_r + 64'd1;
        end else begin
            instret_r <= instret_r;
        end
    end

    assign bus.instret_o = instret_r;
`endif

    assign bus.pc_o          = pc_r;
    assign bus.pc_plus4_o    = pc_r + 32'd4;
    assign bus.epc_o         = epc_r;
    assign bus.fetch_valid_o = fetch_valid_r;
    assign bus.misalign_o    = misalign_r;
    assign bus.state_o       = state_r;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed table-driven bench for pc_sequencer plus hand sequences for reset,
// wrap, stalled trap and double-fault corner cases.
module tb_pc_sequencer;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    pc_sequencer_if bus ();

    pc_sequencer #(
        .RESET_VECTOR (32'h0000_0000),
        .TRAP_VECTOR  (32'h0000_0100)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic        stall;
        logic        br;
        logic [31:0] bt;
        logic        jmp;
        logic [31:0] jt;
        logic        trap;
        logic        mret;
        logic [31:0] pc;
        logic [31:0] epc;
        logic [1:0]  st;
        logic        fv;
        logic        mis;
        logic [63:0] ir;
    } vec_t;

    vec_t vecs[25];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input vec_t v);
        chk({tag, " pc"}, {32'd0, bus.pc_o}, {32'd0, v.pc});
        chk({tag, " pc_plus4"}, {32'd0, bus.pc_plus4_o}, {32'd0, v.pc + 32'd4});
        chk({tag, " epc"}, {32'd0, bus.epc_o}, {32'd0, v.epc});
        chk({tag, " state"}, {62'd0, bus.state_o}, {62'd0, v.st});
        chk({tag, " fetch_valid"}, {63'd0, bus.fetch_valid_o}, {63'd0, v.fv});
        chk({tag, " misalign"}, {63'd0, bus.misalign_o}, {63'd0, v.mis});
    endtask

    task automatic drive(input vec_t v);
        bus.stall_i         = v.stall;
        bus.branch_taken_i  = v.br;
        bus.branch_target_i = v.bt;
        bus.jump_i          = v.jmp;
        bus.jump_target_i   = v.jt;
        bus.trap_i          = v.trap;
        bus.mret_i          = v.mret;
    endtask

    task automatic step(input string tag, input vec_t v);
        drive(v);
        @(posedge clk);
        #1;
        check_outs(tag, v);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        //            stall br  bt           jmp jt            trap mret pc             epc           st    fv    mis   ir
        vecs[0]  = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,        1'b0, 1'b0, 32'h00,       32'h0,  2'd1, 1'b1, 1'b0, 64'd0};
        vecs[1]  = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,        1'b0, 1'b0, 32'h04,       32'h0,  2'd1, 1'b1, 1'b0, 64'd1};
        vecs[2]  = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,        1'b0, 1'b0, 32'h08,       32'h0,  2'd1, 1'b1, 1'b0, 64'd2};
        vecs[3]  = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,        1'b0, 1'b0, 32'h0C,       32'h0,  2'd1, 1'b1, 1'b0, 64'd3};
        vecs[4]  = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,        1'b0, 1'b0, 32'h10,       32'h0,  2'd1, 1'b1, 1'b0, 64'd4};
        vecs[5]  = '{1'b0, 1'b1, 32'h40,  1'b0, 32'h0,        1'b0, 1'b0, 32'h40,       32'h0,  2'd1, 1'b1, 1'b0, 64'd5};
        vecs[6]  = '{1'b0, 1'b1, 32'h40,  1'b1, 32'h80,       1'b0, 1'b0, 32'h80,       32'h0,  2'd1, 1'b1, 1'b0, 64'd6};
        vecs[7]  = '{1'b1, 1'b0, 32'h0,   1'b0, 32'h0,        1'b0, 1'b0, 32'h80,       32'h0,  2'd1, 1'b1, 1'b0, 64'd6};
        vecs[8]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h200,      1'b0, 1'b0, 32'h80,       32'h0,  2'd1, 1'b1, 1'b0, 64'd6};
        vecs[9]  = '{1'b1, 1'b1, 32'h44,  1'b0, 32'h0,        1'b0, 1'b0, 32'h80,       32'h0,  2'd1, 1'b1, 1'b0, 64'd6};
        vecs[10] = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h20,       1'b0, 1'b0, 32'h20,       32'h0,  2'd1, 1'b1, 1'b0, 64'd7};
        vecs[11] = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,        1'b0, 1'b0, 32'h24,       32'h0,  2'd1, 1'b1, 1'b0, 64'd8};
        vecs[12] = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,        1'b1, 1'b0, 32'h100,      32'h24, 2'd2, 1'b1, 1'b0, 64'd8};
        vecs[13] = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,        1'b0, 1'b0, 32'h104,      32'h24, 2'd2, 1'b1, 1'b0, 64'd9};
        vecs[14] = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,        1'b0, 1'b0, 32'h108,      32'h24, 2'd2, 1'b1, 1'b0, 64'd10};
        vecs[15] = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,        1'b0, 1'b1, 32'h24,       32'h24, 2'd1, 1'b1, 1'b0, 64'd11};
        vecs[16] = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,        1'b0, 1'b1, 32'h28,       32'h24, 2'd1, 1'b1, 1'b0, 64'd12};
        vecs[17] = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,        1'b0, 1'b0, 32'h2C,       32'h24, 2'd1, 1'b1, 1'b0, 64'd13};
        vecs[18] = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,        1'b0, 1'b0, 32'h30,       32'h24, 2'd1, 1'b1, 1'b0, 64'd14};
        vecs[19] = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h42,       1'b0, 1'b0, 32'h100,      32'h30, 2'd2, 1'b1, 1'b1, 64'd14};
        vecs[20] = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,        1'b0, 1'b0, 32'h104,      32'h30, 2'd2, 1'b1, 1'b0, 64'd15};
        vecs[21] = '{1'b1, 1'b1, 32'h43,  1'b0, 32'h0,        1'b0, 1'b0, 32'h104,      32'h30, 2'd2, 1'b1, 1'b0, 64'd15};
        vecs[22] = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,        1'b1, 1'b0, 32'h104,      32'h30, 2'd3, 1'b0, 1'b0, 64'd15};
        vecs[23] = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h8,        1'b0, 1'b0, 32'h104,      32'h30, 2'd3, 1'b0, 1'b0, 64'd15};
        vecs[24] = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,        1'b1, 1'b1, 32'h104,      32'h30, 2'd3, 1'b0, 1'b0, 64'd15};

        drive('{1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 1'b0, 64'd0});
        #12;
        check_outs("reset", '{1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 1'b0, 64'd0});
`ifdef PC_SEQ_INSTRET_EN
        chk("reset instret", bus.instret_o, 64'd0);
`endif
        rst_n = 1'b1;
        #1;
        check_outs("boot", '{1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 1'b0, 64'd0});

        for (int i = 0; i < 25; i++) begin
            step($sformatf("vec%0d", i), vecs[i]);
`ifdef PC_SEQ_INSTRET_EN
            chk($sformatf("vec%0d instret", i), bus.instret_o, vecs[i].ir);
`endif
        end

        // Reset out of HALT, then wrap and stalled trap.
        rst_n = 1'b0;
        #1;
        check_outs("halt reset", '{1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 1'b0, 64'd0});
        drive('{1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 1'b0, 64'd0});
        #2;
        rst_n = 1'b1;
        step("w boot", '{1'b0, 1'b0, 32'h0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         32'h0, 2'd1, 1'b1, 1'b0, 64'd0});
        step("w jump", '{1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0, 2'd1, 1'b1, 1'b0, 64'd0});
        step("w wrap", '{1'b0, 1'b0, 32'h0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         32'h0, 2'd1, 1'b1, 1'b0, 64'd0});
        step("w stall trap", '{1'b1, 1'b0, 32'h0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h100,       32'h0, 2'd2, 1'b1, 1'b0, 64'd0});

        // Asynchronous reset mid-HANDLER, checked before the next rising edge.
        drive('{1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 1'b0, 64'd0});
        #2;
        rst_n = 1'b0;
        #1;
        check_outs("async reset", '{1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 1'b0, 64'd0});
`ifdef PC_SEQ_INSTRET_EN
        chk("async reset instret", bus.instret_o, 64'd0);
`endif
        #1;
        rst_n = 1'b1;

        // Misaligned branch while already in HANDLER: halt, pulse still raised.
        step("d boot",  '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0, 1'b0, 1'b0, 32'h0,   32'h0, 2'd1, 1'b1, 1'b0, 64'd0});
        step("d trap",  '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0, 1'b1, 1'b0, 32'h100, 32'h0, 2'd2, 1'b1, 1'b0, 64'd0});
        step("d misbr", '{1'b0, 1'b1, 32'h102, 1'b0, 32'h0, 1'b0, 1'b0, 32'h100, 32'h0, 2'd3, 1'b0, 1'b1, 64'd0});
        step("d halt",  '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0, 1'b0, 1'b0, 32'h100, 32'h0, 2'd3, 1'b0, 1'b0, 64'd0});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
